fpu_wb_merge: RTL

- Sits directly downstream of the execute stage's FPU issue ports. It collects result completions from NUM_SRC floating-point result channels (fadd/fsub/fmul/fdiv/… outputs, upper and lower lanes multiplexed by the FPU wrapper).
- Completions arrive with unequal latencies, so several can land in the same cycle. This block serialises them through an in-order buffer onto the two float-register-file write ports.
- When the buffer nears capacity it raises an interlock back to exec.

---
 rtl/fpu_wb_merge_if.sv | 34 +++
 rtl/fpu_wb_merge.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fpu_wb_merge_if.sv
// FPU writeback merge bus: per-channel completion inputs, two register-file write ports, status.
// The master drives completions (exec side); the slave is the merge block.
interface fpu_wb_merge_if #(
    parameter int NUM_SRC = 4,
    parameter int DEPTH   = 8,
    parameter int CW      = $clog2(DEPTH + 1)
);
    logic [NUM_SRC-1:0]    src_valid;
    logic [5*NUM_SRC-1:0]  src_rt;
    logic [32*NUM_SRC-1:0] src_data;

    logic                  wr0_en;
    logic [4:0]            wr0_addr;
    logic [31:0]           wr0_data;
    logic                  wr1_en;
    logic [4:0]            wr1_addr;
    logic [31:0]           wr1_data;

    logic                  interlock;
    logic [CW-1:0]         count;
    logic                  overflow;

    modport master (
        output src_valid, src_rt, src_data,
        input  wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
        input  interlock, count, overflow
    );

    modport slave (
        input  src_valid, src_rt, src_data,
        output wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
        output interlock, count, overflow
    );
endinterface

// File: rtl/fpu_wb_merge.sv
// Serialises same-cycle FPU completions in order onto two FP regfile write ports; 1-cycle latency.
// No backpressure from the regfile; interlock asks exec to stop issuing once the buffer nears full.
module fpu_wb_merge #(
    parameter int NUM_SRC = 4,
    parameter int DEPTH   = 8,
    parameter int CW      = $clog2(DEPTH + 1)
) (
    input logic           clk,
    input logic           rst,
    fpu_wb_merge_if.slave bus
);
    localparam int PW  = $clog2(DEPTH);
    localparam int IXW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef struct packed {
        logic [4:0]  rt;
        logic [31:0] data;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    entry_t        inc   [NUM_SRC];
    entry_t        e0;
    entry_t        e1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          wr0_en_q, wr0_en_d;
    logic          wr1_en_q, wr1_en_d;
    logic [4:0]    wr0_addr_q, wr0_addr_d;
    logic [4:0]    wr1_addr_q, wr1_addr_d;
    logic [31:0]   wr0_data_q, wr0_data_d;
    logic [31:0]   wr1_data_q, wr1_data_d;

    int n_in, cnt, tot, pops, use_in, kept, n_wr;

    always_comb begin
        mem_d = mem_q;
        n_in  = 0;
        n_wr  = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            inc[i] = '0;
        end
        // Compact this cycle's valid channels, lowest index first.
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.src_valid[i]) begin
                inc[n_in[IXW-1:0]] = '{rt: bus.src_rt[5*i +: 5], data: bus.src_data[32*i +: 32]};
                n_in = n_in + 1;
            end
        end

        cnt    = int'(count_q);
        tot    = cnt + n_in;
        pops   = (cnt < 2) ? cnt : 2;
        use_in = ((tot < 2) ? tot : 2) - pops;

        e0 = (cnt >= 1) ? mem_q[head_q] : inc[0];
        e1 = (cnt >= 2) ? mem_q[head_q + PW'(1)] : ((cnt == 1) ? inc[0] : inc[1]);

        // Leftover completions are appended behind the survivors; the youngest are dropped once full.
        kept = cnt - pops;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (j >= use_in && j < n_in && kept < DEPTH) begin
                mem_d[tail_q + PW'(n_wr)] = inc[j];
                n_wr = n_wr + 1;
                kept = kept + 1;
            end
        end

        head_d     = head_q + PW'(pops);
        tail_d     = tail_q + PW'(n_wr);
        count_d    = CW'(kept);
        overflow_d = overflow_q | ((tot - 2) > DEPTH);

        wr0_en_d   = (tot >= 1);
        wr1_en_d   = (tot >= 2);
        wr0_addr_d = wr0_en_d ? e0.rt   : wr0_addr_q;
        wr0_data_d = wr0_en_d ? e0.data : wr0_data_q;
        wr1_addr_d = wr1_en_d ? e1.rt   : wr1_addr_q;
        wr1_data_d = wr1_en_d ? e1.data : wr1_data_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            wr0_en_q   <= 1'b0;
            wr1_en_q   <= 1'b0;
            wr0_addr_q <= '0;
            wr1_addr_q <= '0;
            wr0_data_q <= '0;
            wr1_data_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            wr0_en_q   <= wr0_en_d;
            wr1_en_q   <= wr1_en_d;
            wr0_addr_q <= wr0_addr_d;
            wr1_addr_q <= wr1_addr_d;
            wr0_data_q <= wr0_data_d;
            wr1_data_q <= wr1_data_d;
        end
    end

    // Storage needs no reset: occupancy is tracked solely by count_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.wr0_en    = wr0_en_q;
    assign bus.wr0_addr  = wr0_addr_q;
    assign bus.wr0_data  = wr0_data_q;
    assign bus.wr1_en    = wr1_en_q;
    assign bus.wr1_addr  = wr1_addr_q;
    assign bus.wr1_data  = wr1_data_q;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.interlock = (count_q > CW'(DEPTH - NUM_SRC));
endmodule
